cci_mpf_prim_scoreboard_tagger: RTL and testbench

Front end for the ordered-response scoreboard path: accepts requests from the client, allocates a scoreboard slot per request, and forwards each request downstream tagged with its slot index. Memory responses come back out of order with that tag. The block registers them and writes the payload into the scoreboard's data port. It also tracks which tags are outstanding and flags responses whose tag was never allocated or was already answered.

---
 rtl/cci_mpf_prim_scoreboard_tagger.sv | 139 +++++++++++++
 tb/tb_cci_mpf_prim_scoreboard_tagger.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_prim_scoreboard_tagger.sv
// Scoreboard front end: allocates a slot per client request, forwards the
// request tagged with that slot, registers out-of-order responses and writes
// them into the scoreboard data port. Tracks outstanding tags and flags
// responses that do not match a pending tag.
module cci_mpf_prim_scoreboard_tagger #(
  parameter int N_ENTRIES       = 32,
  parameter int N_DATA_BITS     = 64,
  parameter int N_META_BITS     = 1,
  parameter int N_REQ_BITS      = 64,
  parameter int MAX_OUTSTANDING = N_ENTRIES
) (
  input  logic                                   clk,
  input  logic                                   reset,

  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [N_REQ_BITS-1:0]                  req_data,
  input  logic [N_META_BITS-1:0]                 req_meta,

  output logic                                   sb_enq_en,
  output logic [N_META_BITS-1:0]                 sb_enqMeta,
  input  logic                                   sb_notFull,
  input  logic [$clog2(N_ENTRIES)-1:0]           sb_enqIdx,

  output logic                                   mem_req_valid,
  input  logic                                   mem_req_ready,
  output logic [N_REQ_BITS-1:0]                  mem_req_data,
  output logic [$clog2(N_ENTRIES)-1:0]           mem_req_tag,

  input  logic                                   mem_rsp_valid,
  input  logic [$clog2(N_ENTRIES)-1:0]           mem_rsp_tag,
  input  logic [N_DATA_BITS-1:0]                 mem_rsp_data,

  output logic                                   sb_enqData_en,
  output logic [$clog2(N_ENTRIES)-1:0]           sb_enqDataIdx,
  output logic [N_DATA_BITS-1:0]                 sb_enqData,

  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   n_outstanding,
  output logic                                   rsp_err
);

  localparam int T  = $clog2(N_ENTRIES);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic                   mem_req_valid_q, mem_req_valid_d;
  logic [N_REQ_BITS-1:0]  mem_req_data_q,  mem_req_data_d;
  logic [T-1:0]           mem_req_tag_q,   mem_req_tag_d;
  logic [N_ENTRIES-1:0]   pend_q,          pend_d;
  logic                   rsp_v_q;
  logic [T-1:0]           rsp_tag_q;
  logic [N_DATA_BITS-1:0] rsp_data_q;
  logic [CW-1:0]          cnt_q,           cnt_d;
  logic                   rsp_err_q,       rsp_err_d;

  logic accept;
  logic pend_hit;
  logic ok;
  logic rsp_bad;

  // Request acceptance and response validation against the pending bitmap
  always_comb begin
    req_ready = !reset && sb_notFull && (cnt_q < MAX_CNT) &&
                (!mem_req_valid_q || mem_req_ready);
    accept    = req_valid && req_ready;
    pend_hit  = pend_q[rsp_tag_q];
    ok        = !reset && rsp_v_q && pend_hit;
    rsp_bad   = rsp_v_q && !pend_hit;
  end

  // Next-state: output register, pending bitmap, credit counter, error flag
  always_comb begin
    mem_req_valid_d = mem_req_valid_q;
    mem_req_data_d  = mem_req_data_q;
    mem_req_tag_d   = mem_req_tag_q;
    pend_d          = pend_q;
    cnt_d           = cnt_q;
    rsp_err_d       = rsp_err_q | rsp_bad;

    if (accept) begin
      mem_req_valid_d = 1'b1;
      mem_req_data_d  = req_data;
      mem_req_tag_d   = sb_enqIdx;
    end else if (mem_req_ready) begin
      mem_req_valid_d = 1'b0;
    end

    // Clear before set so a same-cycle reallocation of the slot keeps it pending
    if (ok)     pend_d[rsp_tag_q] = 1'b0;
    if (accept) pend_d[sb_enqIdx] = 1'b1;

    case ({accept, ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_valid_q <= 1'b0;
      pend_q          <= '0;
      rsp_v_q         <= 1'b0;
      cnt_q           <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      mem_req_valid_q <= mem_req_valid_d;
      pend_q          <= pend_d;
      rsp_v_q         <= mem_rsp_valid;
      cnt_q           <= cnt_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  // Payload and tag registers need no reset; they are qualified by valids
  always_ff @(posedge clk) begin
    mem_req_data_q <= mem_req_data_d;
    mem_req_tag_q  <= mem_req_tag_d;
    rsp_tag_q      <= mem_rsp_tag;
    rsp_data_q     <= mem_rsp_data;
  end

  // Output wiring
  always_comb begin
    sb_enq_en     = accept;
    sb_enqMeta    = req_meta;
    mem_req_valid = mem_req_valid_q;
    mem_req_data  = mem_req_data_q;
    mem_req_tag   = mem_req_tag_q;
    sb_enqData_en = ok;
    sb_enqDataIdx = rsp_tag_q;
    sb_enqData    = rsp_data_q;
    n_outstanding = cnt_q;
    rsp_err       = rsp_err_q;
  end

endmodule

// File: tb/tb_cci_mpf_prim_scoreboard_tagger.sv
// Self-checking bench for cci_mpf_prim_scoreboard_tagger: directed scenarios
// plus a randomized run against a cycle-level behavioural model.
module tb_cci_mpf_prim_scoreboard_tagger;

  localparam int NE   = 16;
  localparam int ND   = 32;
  localparam int NM   = 2;
  localparam int NR   = 32;
  localparam int MAXO = 8;
  localparam int TW   = 4;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [NR-1:0] req_data = '0;
  logic [NM-1:0] req_meta = '0;
  logic          sb_enq_en;
  logic [NM-1:0] sb_enqMeta;
  logic          sb_notFull = 1'b1;
  logic [TW-1:0] sb_enqIdx = '0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic [NR-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_rsp_valid = 1'b0;
  logic [TW-1:0] mem_rsp_tag = '0;
  logic [ND-1:0] mem_rsp_data = '0;
  logic          sb_enqData_en;
  logic [TW-1:0] sb_enqDataIdx;
  logic [ND-1:0] sb_enqData;
  logic [CW-1:0] n_outstanding;
  logic          rsp_err;

  int vectors = 0;
  int miscompares = 0;

  cci_mpf_prim_scoreboard_tagger #(
    .N_ENTRIES(NE), .N_DATA_BITS(ND), .N_META_BITS(NM),
    .N_REQ_BITS(NR), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_meta(req_meta),
    .sb_enq_en(sb_enq_en), .sb_enqMeta(sb_enqMeta), .sb_notFull(sb_notFull), .sb_enqIdx(sb_enqIdx),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data),
    .sb_enqData_en(sb_enqData_en), .sb_enqDataIdx(sb_enqDataIdx), .sb_enqData(sb_enqData),
    .n_outstanding(n_outstanding), .rsp_err(rsp_err)
  );

  initial forever #5 clk = ~clk;

  // Behavioural model: set of pending tags, a credit count, the single
  // forwarded request slot, and last cycle's response.
  bit            m_pend[NE];
  bit            m_answered[NE];
  int            m_out;
  bit            m_err;
  bit            m_mv;
  logic [TW-1:0] m_mtag;
  logic [NR-1:0] m_mdata;
  bit            m_rv;
  logic [TW-1:0] m_rtag;
  logic [ND-1:0] m_rdata;

  function automatic bit m_ready();
    return !reset && sb_notFull && (m_out < MAXO) && (!m_mv || mem_req_ready);
  endfunction

  function automatic bit m_ok();
    return !reset && m_rv && m_pend[m_rtag];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NE; i++) begin m_pend[i] = 0; m_answered[i] = 0; end
    m_out = 0; m_err = 0; m_mv = 0; m_rv = 0;
  endtask

  // One clock: sample inputs, advance model at posedge, return at negedge
  task automatic tick();
    bit acc, okv, bad, mrdy, in_rv;
    logic [TW-1:0] idx, in_rtag;
    logic [NR-1:0] d;
    logic [ND-1:0] in_rd;
    acc = req_valid && m_ready();
    okv = m_ok();
    bad = m_rv && !m_pend[m_rtag];
    idx = sb_enqIdx; d = req_data; mrdy = mem_req_ready;
    in_rv = mem_rsp_valid; in_rtag = mem_rsp_tag; in_rd = mem_rsp_data;
    @(posedge clk);
    if (!reset) begin
      if (okv) m_pend[m_rtag] = 0;
      if (acc) begin m_pend[idx] = 1; m_answered[idx] = 0; end
      m_out = m_out + int'(acc) - int'(okv);
      if (bad) m_err = 1;
      if (acc) begin m_mv = 1; m_mtag = idx; m_mdata = d; end
      else if (mrdy) m_mv = 0;
      m_rv = in_rv; m_rtag = in_rtag; m_rdata = in_rd;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = 0; sb_notFull = 1; mem_req_ready = 1; mem_rsp_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 reset = 1;
    m_reset();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    req_valid = 1;
    #2 reset = 1;
    m_reset();
    #1;
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
    vectors++; if (n_outstanding !== '0) begin miscompares++; $display("FAIL reset_n_outstanding: got %0d want 0", n_outstanding); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    vectors++; if (sb_enq_en !== 1'b0) begin miscompares++; $display("FAIL reset_sb_enq_en: got %b want 0", sb_enq_en); end
    vectors++; if (sb_enqData_en !== 1'b0) begin miscompares++; $display("FAIL reset_sb_enqData_en: got %b want 0", sb_enqData_en); end
    tick(); tick();
    vectors++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_hold: got valid=%b ready=%b want 0 0", mem_req_valid, req_ready); end
    reset = 0; req_valid = 0;
  endtask

  task automatic test_first_request();
    logic [NR-1:0] d;
    logic [ND-1:0] r;
    d = $urandom; r = $urandom;
    req_valid = 1; req_data = d; req_meta = 2'b10; sb_enqIdx = 4'd3;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL first_req_ready: got %b want 1", req_ready); end
    vectors++; if (sb_enq_en !== 1'b1) begin miscompares++; $display("FAIL first_sb_enq_en: got %b want 1", sb_enq_en); end
    vectors++; if (sb_enqMeta !== 2'b10) begin miscompares++; $display("FAIL first_sb_enqMeta: got %b want 10", sb_enqMeta); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL first_not_yet_valid: got %b want 0", mem_req_valid); end
    tick();
    req_valid = 0;
    #1;
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_tag !== 4'd3 || mem_req_data !== d) begin
      miscompares++; $display("FAIL first_forward: got v=%b tag=%0d data=%h want 1 3 %h", mem_req_valid, mem_req_tag, mem_req_data, d); end
    tick();
    vectors++; if (mem_req_valid !== 1'b0 || n_outstanding !== 4'd1) begin
      miscompares++; $display("FAIL first_drain: got v=%b n=%0d want 0 1", mem_req_valid, n_outstanding); end
    mem_rsp_valid = 1; mem_rsp_tag = 4'd3; mem_rsp_data = r;
    tick();
    mem_rsp_valid = 0;
    #1;
    vectors++; if (sb_enqData_en !== 1'b1 || sb_enqDataIdx !== 4'd3 || sb_enqData !== r) begin
      miscompares++; $display("FAIL first_rsp_write: got en=%b idx=%0d data=%h want 1 3 %h", sb_enqData_en, sb_enqDataIdx, sb_enqData, r); end
    tick();
    vectors++; if (n_outstanding !== 4'd0 || rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL first_retire: got n=%0d err=%b want 0 0", n_outstanding, rsp_err); end
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] d[8];
    logic [TW-1:0] order[8];
    logic [ND-1:0] rd[8];
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      d[i] = $urandom;
      req_valid = 1; sb_enqIdx = TW'(i); req_data = d[i];
      #1;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
      if (i > 0) begin
        vectors++; if (mem_req_valid !== 1'b1 || mem_req_tag !== TW'(i - 1) || mem_req_data !== d[i-1]) begin
          miscompares++; $display("FAIL b2b_forward[%0d]: got v=%b tag=%0d want 1 %0d", i - 1, mem_req_valid, mem_req_tag, i - 1); end
      end
      tick();
    end
    req_valid = 0;
    #1;
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_tag !== 4'd7 || mem_req_data !== d[7]) begin
      miscompares++; $display("FAIL b2b_forward[7]: got v=%b tag=%0d want 1 7", mem_req_valid, mem_req_tag); end
    vectors++; if (n_outstanding !== 4'd8) begin miscompares++; $display("FAIL b2b_count: got %0d want 8", n_outstanding); end
    // Credit limit reached: a ninth request must wait for a response
    req_valid = 1; sb_enqIdx = 4'd8; req_data = $urandom;
    mem_rsp_valid = 1; mem_rsp_tag = 4'd0; mem_rsp_data = $urandom;
    #1;
    vectors++; if (req_ready !== 1'b0 || sb_enq_en !== 1'b0) begin
      miscompares++; $display("FAIL credit_block: got ready=%b en=%b want 0 0", req_ready, sb_enq_en); end
    tick();
    mem_rsp_valid = 0;
    #1;
    vectors++; if (sb_enqData_en !== 1'b1 || req_ready !== 1'b0) begin
      miscompares++; $display("FAIL credit_n1: got wr=%b ready=%b want 1 0", sb_enqData_en, req_ready); end
    tick();
    #1;
    vectors++; if (req_ready !== 1'b1 || n_outstanding !== 4'd7) begin
      miscompares++; $display("FAIL credit_return: got ready=%b n=%0d want 1 7", req_ready, n_outstanding); end
    tick();
    req_valid = 0;
    for (int i = 0; i < 8; i++) order[i] = TW'(i + 1);
    for (int i = 7; i > 0; i--) begin
      int j;
      logic [TW-1:0] t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        rd[k] = $urandom;
        mem_rsp_valid = 1; mem_rsp_tag = order[k]; mem_rsp_data = rd[k];
      end else mem_rsp_valid = 0;
      #1;
      if (k > 0) begin
        vectors++; if (sb_enqData_en !== 1'b1 || sb_enqDataIdx !== order[k-1] || sb_enqData !== rd[k-1]) begin
          miscompares++; $display("FAIL drain_write[%0d]: got en=%b idx=%0d want 1 %0d", k, sb_enqData_en, sb_enqDataIdx, order[k-1]); end
        vectors++; if (n_outstanding !== CW'(9 - k)) begin
          miscompares++; $display("FAIL drain_count[%0d]: got %0d want %0d", k, n_outstanding, 9 - k); end
      end
      tick();
    end
    vectors++; if (n_outstanding !== 4'd0 || rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL drain_final: got n=%0d err=%b want 0 0", n_outstanding, rsp_err); end
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] a, b;
    a = $urandom; b = $urandom;
    idle_inputs();
    mem_req_ready = 0; req_valid = 1; sb_enqIdx = 4'd9; req_data = a;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_first_ready: got %b want 1", req_ready); end
    tick();
    sb_enqIdx = 4'd10; req_data = b;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", k, req_ready); end
      vectors++; if (mem_req_valid !== 1'b1 || mem_req_tag !== 4'd9 || mem_req_data !== a) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got v=%b tag=%0d data=%h want 1 9 %h", k, mem_req_valid, mem_req_tag, mem_req_data, a); end
      tick();
    end
    mem_req_ready = 1;
    #1;
    vectors++; if (req_ready !== 1'b1 || mem_req_data !== a) begin
      miscompares++; $display("FAIL bp_release: got ready=%b data=%h want 1 %h", req_ready, mem_req_data, a); end
    tick();
    req_valid = 0;
    #1;
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_tag !== 4'd10 || mem_req_data !== b) begin
      miscompares++; $display("FAIL bp_second: got v=%b tag=%0d data=%h want 1 10 %h", mem_req_valid, mem_req_tag, mem_req_data, b); end
    tick();
    vectors++; if (mem_req_valid !== 1'b0 || n_outstanding !== 4'd2) begin
      miscompares++; $display("FAIL bp_no_dup: got v=%b n=%0d want 0 2", mem_req_valid, n_outstanding); end
    mem_rsp_valid = 1; mem_rsp_tag = 4'd9; tick();
    mem_rsp_tag = 4'd10; tick();
    mem_rsp_valid = 0; tick(); tick();
  endtask

  task automatic test_out_of_order();
    logic [TW-1:0] tags[3];
    logic [ND-1:0] rd[3];
    tags[0] = 4'd2; tags[1] = 4'd0; tags[2] = 4'd1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; sb_enqIdx = TW'(i); req_data = $urandom; tick();
    end
    req_valid = 0;
    #1;
    vectors++; if (n_outstanding !== 4'd3) begin miscompares++; $display("FAIL ooo_count: got %0d want 3", n_outstanding); end
    for (int j = 0; j <= 3; j++) begin
      if (j < 3) begin
        rd[j] = $urandom;
        mem_rsp_valid = 1; mem_rsp_tag = tags[j]; mem_rsp_data = rd[j];
      end else mem_rsp_valid = 0;
      #1;
      if (j > 0) begin
        vectors++; if (sb_enqData_en !== 1'b1 || sb_enqDataIdx !== tags[j-1] || sb_enqData !== rd[j-1]) begin
          miscompares++; $display("FAIL ooo_write[%0d]: got en=%b idx=%0d data=%h want 1 %0d %h", j - 1, sb_enqData_en, sb_enqDataIdx, sb_enqData, tags[j-1], rd[j-1]); end
        vectors++; if (n_outstanding !== CW'(4 - j)) begin
          miscompares++; $display("FAIL ooo_step[%0d]: got %0d want %0d", j, n_outstanding, 4 - j); end
      end
      tick();
    end
    #1;
    vectors++; if (n_outstanding !== 4'd0 || rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL ooo_final: got n=%0d err=%b want 0 0", n_outstanding, rsp_err); end
  endtask

  task automatic test_error();
    idle_inputs();
    mem_rsp_valid = 1; mem_rsp_tag = 4'd5; mem_rsp_data = $urandom;
    tick();
    mem_rsp_valid = 0;
    #1;
    vectors++; if (sb_enqData_en !== 1'b0) begin miscompares++; $display("FAIL err_unalloc_write: got %b want 0", sb_enqData_en); end
    tick();
    vectors++; if (rsp_err !== 1'b1 || n_outstanding !== 4'd0) begin
      miscompares++; $display("FAIL err_unalloc: got err=%b n=%0d want 1 0", rsp_err, n_outstanding); end
    req_valid = 1; sb_enqIdx = 4'd4; tick();
    sb_enqIdx = 4'd6; tick();
    req_valid = 0;
    mem_rsp_valid = 1; mem_rsp_tag = 4'd4; tick();
    mem_rsp_valid = 0; tick(); tick();
    vectors++; if (n_outstanding !== 4'd1) begin miscompares++; $display("FAIL err_first_answer: got %0d want 1", n_outstanding); end
    mem_rsp_valid = 1; mem_rsp_tag = 4'd4; mem_rsp_data = $urandom; tick();
    mem_rsp_valid = 0;
    #1;
    vectors++; if (sb_enqData_en !== 1'b0) begin miscompares++; $display("FAIL err_dup_write: got %b want 0", sb_enqData_en); end
    tick(); tick(); tick();
    vectors++; if (rsp_err !== 1'b1 || n_outstanding !== 4'd1) begin
      miscompares++; $display("FAIL err_dup_sticky: got err=%b n=%0d want 1 1", rsp_err, n_outstanding); end
  endtask

  task automatic test_random();
    logic [TW-1:0] fl[$];
    logic [TW-1:0] pl[$];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      sb_notFull    = ($urandom_range(0, 7) != 0);
      mem_req_ready = ($urandom_range(0, 3) != 0);
      req_valid     = ($urandom_range(0, 2) != 0);
      req_data      = $urandom;
      req_meta      = NM'($urandom_range(0, 3));
      if (m_ok() && $urandom_range(0, 3) == 0) sb_enqIdx = m_rtag;
      else begin
        fl.delete();
        for (int i = 0; i < NE; i++) if (!m_pend[i]) fl.push_back(TW'(i));
        if (fl.size() == 0) begin sb_notFull = 0; sb_enqIdx = '0; end
        else sb_enqIdx = fl[$urandom_range(0, fl.size() - 1)];
      end
      mem_rsp_valid = 0;
      mem_rsp_data  = $urandom;
      if ($urandom_range(0, 31) == 0) begin
        mem_rsp_valid = 1; mem_rsp_tag = TW'($urandom_range(0, NE - 1));
      end else if ($urandom_range(0, 1) == 0) begin
        pl.delete();
        for (int i = 0; i < NE; i++) if (m_pend[i] && !m_answered[i]) pl.push_back(TW'(i));
        if (pl.size() != 0) begin
          mem_rsp_valid = 1; mem_rsp_tag = pl[$urandom_range(0, pl.size() - 1)];
          m_answered[mem_rsp_tag] = 1;
        end
      end
      #1;
      vectors++; if (req_ready !== m_ready() || sb_enq_en !== (req_valid && m_ready()) || sb_enqMeta !== req_meta) begin
        miscompares++; $display("FAIL rnd_accept[%0d]: got ready=%b en=%b want %b %b", c, req_ready, sb_enq_en, m_ready(), req_valid && m_ready()); end
      vectors++; if (mem_req_valid !== m_mv || (m_mv && (mem_req_tag !== m_mtag || mem_req_data !== m_mdata))) begin
        miscompares++; $display("FAIL rnd_fwd[%0d]: got v=%b tag=%0d want %b %0d", c, mem_req_valid, mem_req_tag, m_mv, m_mtag); end
      vectors++; if (sb_enqData_en !== m_ok() || (m_ok() && (sb_enqDataIdx !== m_rtag || sb_enqData !== m_rdata))) begin
        miscompares++; $display("FAIL rnd_write[%0d]: got en=%b idx=%0d want %b %0d", c, sb_enqData_en, sb_enqDataIdx, m_ok(), m_rtag); end
      vectors++; if (n_outstanding !== CW'(m_out) || rsp_err !== m_err) begin
        miscompares++; $display("FAIL rnd_state[%0d]: got n=%0d err=%b want %0d %b", c, n_outstanding, rsp_err, m_out, m_err); end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; sb_enqIdx = TW'(i); req_data = $urandom; tick();
    end
    req_valid = 0;
    #1;
    vectors++; if (n_outstanding !== 4'd3 || rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL mid_pre: got n=%0d err=%b want 3 0", n_outstanding, rsp_err); end
    req_valid = 1; sb_notFull = 1;
    #2 reset = 1;
    m_reset();
    #1;
    vectors++; if (n_outstanding !== 4'd0 || mem_req_valid !== 1'b0) begin
      miscompares++; $display("FAIL mid_async_clear: got n=%0d v=%b want 0 0", n_outstanding, mem_req_valid); end
    vectors++; if (req_ready !== 1'b0 || sb_enq_en !== 1'b0 || sb_enqData_en !== 1'b0) begin
      miscompares++; $display("FAIL mid_gated: got ready=%b en=%b wr=%b want 0 0 0", req_ready, sb_enq_en, sb_enqData_en); end
    tick();
    reset = 0; req_valid = 0;
    mem_rsp_valid = 1; mem_rsp_tag = 4'd1; mem_rsp_data = $urandom;
    tick();
    mem_rsp_valid = 0;
    #1;
    vectors++; if (sb_enqData_en !== 1'b0) begin miscompares++; $display("FAIL mid_late_write: got %b want 0", sb_enqData_en); end
    tick();
    vectors++; if (rsp_err !== 1'b1 || n_outstanding !== 4'd0) begin
      miscompares++; $display("FAIL mid_late_err: got err=%b n=%0d want 1 0", rsp_err, n_outstanding); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_first_request();
    test_back_to_back();
    test_backpressure();
    test_out_of_order();
    test_error();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
